// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in / serial-out transmit register.
//
// A WIDTH-bit word is accepted over a valid/ready handshake. It is then
// shifted out on sdo, holding each bit for BIT_CYCLES clocks. sdo_valid
// frames the bits, and frame_done pulses for one cycle after the last bit.
// reset_n is an asynchronous active-low reset. set_n is a synchronous
// active-low abort that forces the line idle.
//
// Optional feature macro: PARITY_EN
//   When defined, an even-parity bit (XOR of the loaded word) is appended
//   after the WIDTH data bits, so the frame is WIDTH+1 bits long.
//
// Ports:
//   clk         clock, rising edge
//   reset_n     asynchronous active-low reset
//   set_n       synchronous active-low abort to idle
//   load_valid  load_data is valid
//   load_ready  block can accept a word (combinational)
//   load_data   word to transmit
//   sdo         serial data out, idles high
//   sdo_valid   high while a frame bit is on sdo
//   busy        high while shifting
//   frame_done  one-cycle pulse after the final bit period
module piso_shift_tx #(
   parameter int WIDTH      = 8,
   parameter int BIT_CYCLES = 1,
   parameter int MSB_FIRST  = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             set_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             sdo,
   output logic             sdo_valid,
   output logic             busy,
   output logic             frame_done
);

`ifdef PARITY_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int BW = (NBITS > 1)      ? $clog2(NBITS)      : 1;
   localparam int DW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(BIT_CYCLES - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [NBITS-1:0] sreg;
   logic [BW-1:0]    bit_cnt;
   logic [DW-1:0]    div_cnt;

   logic [NBITS-1:0] frame_word;
   logic [NBITS-1:0] sreg_shifted;
   logic             first_bit;
   logic             next_bit;
   logic             div_wrap;
   logic             last_bit;

   assign load_ready = (state == IDLE) && set_n;

   // The frame word is arranged so that the parity bit sits at the far end
   // of the shift direction. It therefore goes out after every data bit,
   // whatever the bit order.
   always_comb begin
`ifdef PARITY_EN
      if (MSB_FIRST != 0)
         frame_word = {load_data, ^load_data};
      else
         frame_word = {^load_data, load_data};
`else
      frame_word = load_data;
`endif
   end

   // The output end is the MSB for MSB-first and the LSB otherwise. The bit
   // presented after a shift is the neighbour of the current output bit.
   always_comb begin
      if (MSB_FIRST != 0) begin
         first_bit    = frame_word[NBITS-1];
         next_bit     = sreg[NBITS-2];
         sreg_shifted = {sreg[NBITS-2:0], 1'b0};
      end else begin
         first_bit    = frame_word[0];
         next_bit     = sreg[1];
         sreg_shifted = {1'b0, sreg[NBITS-1:1]};
      end
   end

   assign div_wrap = (div_cnt == DIV_LAST);
   assign last_bit = (bit_cnt == BIT_LAST);

   // sdo is registered. It is loaded with the bit that will be on the line
   // in the following cycle, so the first bit appears right after accept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         sreg       <= '0;
         bit_cnt    <= '0;
         div_cnt    <= '0;
         sdo        <= 1'b1;
         sdo_valid  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else if (!set_n) begin
         state      <= IDLE;
         sreg       <= '0;
         bit_cnt    <= '0;
         div_cnt    <= '0;
         sdo        <= 1'b1;
         sdo_valid  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (load_valid) begin
                  state     <= SHIFT;
                  sreg      <= frame_word;
                  bit_cnt   <= '0;
                  div_cnt   <= '0;
                  sdo       <= first_bit;
                  sdo_valid <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            SHIFT: begin
               if (div_wrap) begin
                  div_cnt <= '0;
                  if (last_bit) begin
                     state      <= IDLE;
                     sreg       <= '0;
                     bit_cnt    <= '0;
                     sdo        <= 1'b1;
                     sdo_valid  <= 1'b0;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                  end else begin
                     sreg    <= sreg_shifted;
                     bit_cnt <= bit_cnt + 1'b1;
                     sdo     <= next_bit;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Testbench for piso_shift_tx. Three instances cover the configurations
// exercised: 0 = MSB-first with 2 clocks per bit, 1 = LSB-first with
// 1 clock per bit, and 2 = MSB-first with 1 clock per bit. Expected bit
// sequences are written in send order: seq[k] is the k-th bit on the line,
// and seq[8] is the parity bit when PARITY_EN is defined.
module tb_piso_shift_tx;

`ifdef PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [2:0]      sn = 3'b111;
   logic [2:0]      lv = 3'b000;
   logic [2:0][7:0] ld = '0;
   logic [2:0]      lr, sdo, sv, bsy, fd;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   piso_shift_tx #(.WIDTH(8), .BIT_CYCLES(2), .MSB_FIRST(1)) u_a (
      .clk(clk), .reset_n(reset_n), .set_n(sn[0]), .load_valid(lv[0]),
      .load_ready(lr[0]), .load_data(ld[0]), .sdo(sdo[0]),
      .sdo_valid(sv[0]), .busy(bsy[0]), .frame_done(fd[0]));

   piso_shift_tx #(.WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(0)) u_b (
      .clk(clk), .reset_n(reset_n), .set_n(sn[1]), .load_valid(lv[1]),
      .load_ready(lr[1]), .load_data(ld[1]), .sdo(sdo[1]),
      .sdo_valid(sv[1]), .busy(bsy[1]), .frame_done(fd[1]));

   piso_shift_tx #(.WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1)) u_c (
      .clk(clk), .reset_n(reset_n), .set_n(sn[2]), .load_valid(lv[2]),
      .load_ready(lr[2]), .load_data(ld[2]), .sdo(sdo[2]),
      .sdo_valid(sv[2]), .busy(bsy[2]), .frame_done(fd[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Checks the frame bits in the cycles that follow the current negedge.
   task automatic shift_bits(input int s, input logic [8:0] seq, input int bc);
      for (int k = 0; k < NB; k++) begin
         for (int c = 0; c < bc; c++) begin
            chk("sdo_bit", {31'd0, sdo[s]}, {31'd0, seq[k]});
            chk("sdo_valid", {31'd0, sv[s]}, 32'd1);
            chk("busy", {31'd0, bsy[s]}, 32'd1);
            chk("ready_busy", {31'd0, lr[s]}, 32'd0);
            chk("fd_early", {31'd0, fd[s]}, 32'd0);
            @(negedge clk);
         end
      end
   endtask

   task automatic frame(input int s, input logic [7:0] d, input logic [8:0] seq, input int bc);
      @(negedge clk);
      lv[s] = 1'b1;
      ld[s] = d;
      chk("ready_idle", {31'd0, lr[s]}, 32'd1);
      @(negedge clk);
      lv[s] = 1'b0;
      ld[s] = 8'h00;
      shift_bits(s, seq, bc);
      chk("frame_done", {31'd0, fd[s]}, 32'd1);
      chk("sdo_idle", {31'd0, sdo[s]}, 32'd1);
      chk("valid_idle", {31'd0, sv[s]}, 32'd0);
      chk("busy_idle", {31'd0, bsy[s]}, 32'd0);
      @(negedge clk);
      chk("fd_one_cycle", {31'd0, fd[s]}, 32'd0);
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_sdo", {29'd0, sdo}, 32'h7);
      chk("rst_valid", {29'd0, sv}, 32'h0);
      chk("rst_busy", {29'd0, bsy}, 32'h0);
      chk("rst_fd", {29'd0, fd}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // 1: 0xA5, MSB-first, 2 clocks per bit, parity 0
      frame(0, 8'hA5, 9'b0_1010_0101, 2);

      // 2: 0x0F, LSB-first, parity 0
      frame(1, 8'h0F, 9'b0_0000_1111, 1);

      // 3: back-to-back 0x80 then 0x01, load_valid held high
      @(negedge clk);
      lv[2] = 1'b1;
      ld[2] = 8'h80;
      @(negedge clk);
      ld[2] = 8'h01;
      shift_bits(2, 9'b1_0000_0001, 1);
      chk("b2b_fd", {31'd0, fd[2]}, 32'd1);
      chk("b2b_gap_sdo", {31'd0, sdo[2]}, 32'd1);
      chk("b2b_gap_valid", {31'd0, sv[2]}, 32'd0);
      chk("b2b_ready", {31'd0, lr[2]}, 32'd1);
      @(negedge clk);
      lv[2] = 1'b0;
      shift_bits(2, 9'b1_1000_0000, 1);
      chk("b2b_fd2", {31'd0, fd[2]}, 32'd1);

      // 4: set_n abort during bit 3 of 0xA5 (cycles 7-8 with 2 clocks per bit)
      @(negedge clk);
      lv[0] = 1'b1;
      ld[0] = 8'hA5;
      @(negedge clk);
      lv[0] = 1'b0;
      repeat (6) @(negedge clk);
      chk("abort_pre_sdo", {31'd0, sdo[0]}, 32'd0);
      sn[0] = 1'b0;
      lv[0] = 1'b1;
      ld[0] = 8'h3C;
      chk("abort_ready", {31'd0, lr[0]}, 32'd0);
      @(negedge clk);
      chk("abort_sdo", {31'd0, sdo[0]}, 32'd1);
      chk("abort_valid", {31'd0, sv[0]}, 32'd0);
      chk("abort_busy", {31'd0, bsy[0]}, 32'd0);
      chk("abort_fd", {31'd0, fd[0]}, 32'd0);
      sn[0] = 1'b1;
      lv[0] = 1'b0;
      @(negedge clk);
      chk("abort_no_fd", {31'd0, fd[0]}, 32'd0);
      chk("abort_idle_busy", {31'd0, bsy[0]}, 32'd0);
      frame(0, 8'h3C, 9'b0_0011_1100, 2);

      // 5: asynchronous reset mid-bit
      @(negedge clk);
      lv[1] = 1'b1;
      ld[1] = 8'h0F;
      @(negedge clk);
      lv[1] = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_sdo", {31'd0, sdo[1]}, 32'd1);
      chk("arst_valid", {31'd0, sv[1]}, 32'd0);
      chk("arst_busy", {31'd0, bsy[1]}, 32'd0);
      chk("arst_fd", {31'd0, fd[1]}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("arst_ready", {31'd0, lr[1]}, 32'd1);

      // 6: parity frames (0xA5 -> parity 0, 0x07 -> parity 1)
      frame(2, 8'hA5, 9'b0_1010_0101, 1);
      frame(2, 8'h07, 9'b1_1110_0000, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
